// File: rtl/spi_rx_if.sv
// spi_rx_if: signal bundle between an SPI mode-0 master-side driver and the
// spi_rx receiver.
//
// Signals:
//   data_length_in  frame length in bits (0 or >DATA_WIDTH means DATA_WIDTH)
//   sclk_in         serial clock from the master, asynchronous
//   mosi_in         serial data from the master, asynchronous
//   cs_in           chip select from the master, active-low, asynchronous
//   data_out        last received word, right-aligned, upper bits zero
//   valid_out       one-cycle pulse when data_out updates
//   busy_out        high while a frame is in progress
//   error_out       one-cycle pulse on a frame cut short by cs
//
// Modports:
//   master  drives the serial lines and length, observes the results
//   slave   the receiver side
interface spi_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [5:0]            data_length_in;
  logic                  sclk_in;
  logic                  mosi_in;
  logic                  cs_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  busy_out;
  logic                  error_out;

  modport master (
    output data_length_in, sclk_in, mosi_in, cs_in,
    input  data_out, valid_out, busy_out, error_out
  );

  modport slave (
    input  data_length_in, sclk_in, mosi_in, cs_in,
    output data_out, valid_out, busy_out, error_out
  );
endinterface

// File: rtl/spi_rx.sv
// spi_rx: SPI mode-0 peripheral-side receiver.
//
// Oversamples SCLK/MOSI/CS in the clock_in domain and deserialises MSB-first
// frames of 1..DATA_WIDTH bits. A complete frame is presented right-aligned on
// data_out with a one-cycle valid_out strobe; a frame ended early by cs
// (after at least one bit) gives a one-cycle error_out strobe instead.
//
// Ports:
//   clock_in  system clock, all logic on the rising edge
//   reset_in  asynchronous active-low reset
//   bus       spi_rx_if.slave: data_length_in, sclk_in, mosi_in, cs_in in;
//             data_out, valid_out, busy_out, error_out out
module spi_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic    clock_in,
  input  logic    reset_in,
  spi_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [5:0] MAX_LEN = 6'(DATA_WIDTH);
  localparam int         SET_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(SYNC_STAGES);

  // Out-of-range lengths (0 or above DATA_WIDTH) saturate to a full word.
  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    if ((len == 6'd0) || (len > MAX_LEN)) return MAX_LEN;
    return len;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_hist_q;
  logic                   cs_hist_q;
  logic [SET_W-1:0]       settle_q;
  logic                   armed_q;

  state_t                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [5:0]             len_q, len_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, cs_rise, cs_fall;
  logic settled;

  // Synchroniser outputs and edge detect against the history flops
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;

  // The cs chain resets to '1', so its output is stale for SYNC_STAGES cycles
  // after reset release. Only once it reflects the real pin and shows cs high
  // are falling edges accepted; a cs held low through reset is not a frame.
  assign settled = (settle_q == SET_MAX);

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_in};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
      if (!settled) settle_q <= settle_q + 1'b1;
      armed_q     <= armed_q | (settled & cs_s);
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= MAX_LEN;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          shreg_d = '0;
          cnt_d   = '0;
          len_d   = clamp_len(bus.data_length_in);
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // The L-th bit was shifted in on the previous cycle: publish it.
        // The shift register was cleared at frame start, so upper bits are 0.
        if (cnt_q == len_q) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          state_d = cs_rise ? IDLE : DONE;
        end else if (cs_rise) begin
          // cs beats a coincident sclk rise; that bit is dropped.
          state_d = IDLE;
          error_d = (cnt_q != 6'd0);
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[DATA_WIDTH-2:0], mosi_s};
          cnt_d   = cnt_q + 6'd1;
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.error_out = error_q;
  assign bus.busy_out  = (state_q != IDLE);

endmodule
